// File: rtl/soc_system_clkdiv_gen_if.sv
// Configuration write handshake for soc_system_clkdiv_gen.
// The master drives a channel's div/high/phase and the slave answers with cfg_ready.
interface soc_system_clkdiv_gen_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_write;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;
  logic [CNT_W-1:0] cfg_phase;
  logic             cfg_ready;

  modport master (output cfg_write, cfg_ch, cfg_div, cfg_high, cfg_phase, input cfg_ready);
  modport slave  (input cfg_write, cfg_ch, cfg_div, cfg_high, cfg_phase, output cfg_ready);
endinterface

// File: rtl/soc_system_clkdiv_gen.sv
// Multi-channel run-time programmable clock divider with phase offsets and a lock flag.
// Every channel realigns together whenever any configuration write is accepted.
module soc_system_clkdiv_ch #(
  parameter int CNT_W    = 16,
  parameter int DEF_DIV  = 2,
  parameter int DEF_HIGH = 1
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             wr_i,
  input  logic             align_i,
  input  logic             step_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic [CNT_W-1:0] high_i,
  input  logic [CNT_W-1:0] phase_i,
  output logic             clk_o,
  output logic             en_o,
  output logic             hold_zero_o
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] div_q, high_q, phase_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, hold_q, hold_d, last;
  logic             clk_q, clk_d, en_q, en_d;

  // div of 0 behaves as 1, so the counter wraps at 0
  assign last        = (div_q == '0) ? '0 : div_q - ONE;
  assign hold_zero_o = (hold_q == '0);
  assign clk_o       = clk_q;
  assign en_o        = en_q;

  // Outputs are registered, so they are derived from the counter state of the coming cycle
  always_comb begin
    hold_d = hold_q;
    cnt_d  = cnt_q;
    clk_d  = 1'b0;
    en_d   = 1'b0;
    if (align_i) begin
      hold_d = phase_q;
      cnt_d  = '0;
    end else if (step_i) begin
      if (hold_q != '0) begin
        hold_d = hold_q - ONE;
        cnt_d  = '0;
      end else begin
        cnt_d = (cnt_q == last) ? '0 : cnt_q + ONE;
      end
    end
    if (align_i || step_i) begin
      clk_d = (hold_d == '0) && (cnt_d < high_q);
      en_d  = (hold_d == '0) && (cnt_d == '0) && (high_q != '0);
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      div_q   <= CNT_W'(DEF_DIV);
      high_q  <= CNT_W'(DEF_HIGH);
      phase_q <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      clk_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      if (wr_i) begin
        div_q   <= div_i;
        high_q  <= high_i;
        phase_q <= phase_i;
      end
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      clk_q  <= clk_d;
      en_q   <= en_d;
    end
  end
endmodule

module soc_system_clkdiv_gen #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16,
  parameter int LOCK_DELAY = 8,
  parameter int DEF_DIV    = 2,
  parameter int DEF_HIGH   = 1
) (
  input  logic                    refclk,
  input  logic                    rst,
  soc_system_clkdiv_gen_if.slave  cfg,
  output logic [NUM_CH-1:0]       outclk,
  output logic [NUM_CH-1:0]       outclk_en,
  output logic                    locked
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SC_W = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(LOCK_DELAY - 1);

  typedef enum logic [1:0] {ALIGN, SETTLE, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [SC_W-1:0]   scnt_q, scnt_d;
  logic              ready_q, locked_q;
  logic              accept, align, step, all_hz;
  logic [NUM_CH-1:0] wr, hold_zero;

  assign accept        = cfg.cfg_write && ready_q;
  assign align         = (state_q == ALIGN);
  assign step          = !align && !accept;
  assign all_hz        = &hold_zero;
  assign cfg.cfg_ready = ready_q;
  assign locked        = locked_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range channel numbers match no lane but still trigger realignment
    assign wr[i] = accept && (cfg.cfg_ch == CH_W'(i));

    soc_system_clkdiv_ch #(
      .CNT_W    (CNT_W),
      .DEF_DIV  (DEF_DIV),
      .DEF_HIGH (DEF_HIGH)
    ) u_ch (
      .refclk      (refclk),
      .rst         (rst),
      .wr_i        (wr[i]),
      .align_i     (align),
      .step_i      (step),
      .div_i       (cfg.cfg_div),
      .high_i      (cfg.cfg_high),
      .phase_i     (cfg.cfg_phase),
      .clk_o       (outclk[i]),
      .en_o        (outclk_en[i]),
      .hold_zero_o (hold_zero[i])
    );
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    unique case (state_q)
      ALIGN: begin
        state_d = SETTLE;
        scnt_d  = '0;
      end
      SETTLE: begin
        if (accept) begin
          state_d = ALIGN;
        end else if (all_hz) begin
          if (scnt_q == SC_LAST) state_d = LOCKED;
          else                   scnt_d  = scnt_q + SC_W'(1);
        end
      end
      LOCKED: if (accept) state_d = ALIGN;
      default: state_d = ALIGN;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q  <= ALIGN;
      scnt_q   <= '0;
      ready_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      ready_q  <= (state_d != ALIGN);
      locked_q <= (state_d == LOCKED);
    end
  end
endmodule

// File: tb/tb_soc_system_clkdiv_gen.sv
// Random and directed bench for soc_system_clkdiv_gen against a per-epoch arithmetic model.
module tb_soc_system_clkdiv_gen;
  localparam int NUM_CH     = 5;
  localparam int CNT_W      = 16;
  localparam int LOCK_DELAY = 8;
  localparam int DEF_DIV    = 2;
  localparam int DEF_HIGH   = 1;
  localparam int CH_W       = 3;

  logic              refclk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] outclk, outclk_en;
  logic              locked;

  soc_system_clkdiv_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg ();

  soc_system_clkdiv_gen #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .LOCK_DELAY(LOCK_DELAY),
    .DEF_DIV(DEF_DIV), .DEF_HIGH(DEF_HIGH)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg       (cfg.slave),
    .outclk    (outclk),
    .outclk_en (outclk_en),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int s      = 0;   // first SETTLE cycle of the current alignment epoch
  int mdiv[NUM_CH], mhigh[NUM_CH], mph[NUM_CH];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected outputs follow from elapsed time since the epoch start
  task automatic check_cycle();
    logic [NUM_CH-1:0] eclk, een;
    int maxph, e, m, de;
    eclk = '0;
    een  = '0;
    maxph = 0;
    for (int i = 0; i < NUM_CH; i++) if (mph[i] > maxph) maxph = mph[i];
    if (cyc >= s) begin
      e = cyc - s;
      for (int i = 0; i < NUM_CH; i++) begin
        de = (mdiv[i] == 0) ? 1 : mdiv[i];
        if (e >= mph[i]) begin
          m       = (e - mph[i]) % de;
          eclk[i] = (m < mhigh[i]);
          een[i]  = (m == 0) && (mhigh[i] != 0);
        end
      end
    end
    chk("outclk",    32'(outclk),        32'(eclk));
    chk("outclk_en", 32'(outclk_en),     32'(een));
    chk("locked",    32'(locked),        32'((cyc >= s) && (cyc - s >= maxph + LOCK_DELAY)));
    chk("cfg_ready", 32'(cfg.cfg_ready), 32'(cyc >= s));
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mdiv[i] = DEF_DIV; mhigh[i] = DEF_HIGH; mph[i] = 0;
      end
      s = cyc + 2;
    end else if (cfg.cfg_write && cyc >= s) begin
      if (int'(cfg.cfg_ch) < NUM_CH) begin
        mdiv[cfg.cfg_ch]  = int'(cfg.cfg_div);
        mhigh[cfg.cfg_ch] = int'(cfg.cfg_high);
        mph[cfg.cfg_ch]   = int'(cfg.cfg_phase);
      end
      s = cyc + 2;
    end
  endtask

  task automatic step();
    @(negedge refclk);
    check_cycle();
    @(posedge refclk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic set_cfg(int ch, int dv, int hi, int ph);
    cfg.cfg_ch    = CH_W'(ch);
    cfg.cfg_div   = CNT_W'(dv);
    cfg.cfg_high  = CNT_W'(hi);
    cfg.cfg_phase = CNT_W'(ph);
  endtask

  task automatic wr(int ch, int dv, int hi, int ph);
    set_cfg(ch, dv, hi, ph);
    cfg.cfg_write = 1'b1;
    step();
    cfg.cfg_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cfg.cfg_write = 1'b0;
    set_cfg(0, 0, 0, 0);
    @(posedge refclk);
    model_edge();
    cyc++;
    #1;
    run(2);
    rst = 1'b0;
    run(24);

    wr(1, 5, 2, 0);  run(20);
    wr(0, 4, 2, 0);  run(4);
    wr(2, 4, 2, 3);  run(20);

    wr(3, 0, 1, 0);  run(3);
    wr(4, 1, 1, 0);  run(3);
    wr(0, 4, 0, 0);  run(3);
    wr(1, 4, 9, 0);  run(20);

    // write strobe held across the ALIGN cycle
    set_cfg(3, 6, 3, 1);
    cfg.cfg_write = 1'b1;
    step();
    set_cfg(3, 7, 2, 2);
    step();
    cfg.cfg_write = 1'b0;
    run(20);

    wr(5, 7, 7, 2);  run(15);
    wr(7, 3, 1, 4);  run(20);

    // reset in LOCKED together with a write
    rst = 1'b1;
    set_cfg(1, 9, 4, 2);
    cfg.cfg_write = 1'b1;
    step();
    rst = 1'b0;
    cfg.cfg_write = 1'b0;
    run(20);

    repeat (3000) begin
      if ($urandom_range(0, 24) == 0) begin
        wr(int'($urandom_range(0, 7)), int'($urandom_range(0, 9)),
           int'($urandom_range(0, 10)), int'($urandom_range(0, 6)));
      end else if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        cfg.cfg_write = $urandom_range(0, 1) == 1;
        step();
        rst = 1'b0;
        cfg.cfg_write = 1'b0;
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/soc_system_clkdiv_gen.md
Name: soc_system_clkdiv_gen

Overview:
- Parametrised, run-time reconfigurable multi-channel clock generator. It runs off the PLL output clock.
- Each channel produces a divided square wave with programmable divide ratio, high time and phase offset, plus a one-cycle enable pulse at each rising edge.
- A global locked flag asserts once all channels are phase-aligned and settled. It replaces fixed per-frequency PLL instances for low-rate peripheral clocks and clock enables.

Parameters:
- NUM_CH, 4, number of output channels (1..16).
- CNT_W, 16, width of the divide, high and phase fields and of the internal counters.
- LOCK_DELAY, 8, cycles after phase holds expire before locked asserts (>=1).
- DEF_DIV, 2, reset divide ratio, all channels.
- DEF_HIGH, 1, reset high time, all channels.

Ports:
- refclk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- cfg_write  in  1  configuration write strobe.
- cfg_ch  in  max(1,clog2(NUM_CH))  target channel.
- cfg_div  in  CNT_W  divide ratio.
- cfg_high  in  CNT_W  high time in refclk cycles.
- cfg_phase  in  CNT_W  start delay in refclk cycles.
- cfg_ready  out  1  write accepted this cycle if cfg_write=1.
- outclk  out  NUM_CH  divided clocks (registered).
- outclk_en  out  NUM_CH  one-cycle pulse at each outclk period start.
- locked  out  1  all channels aligned and settled.

Behaviour:
- Reset: while rst=1 at an edge, the following values load:
  - outclk=0, outclk_en=0, locked=0, cfg_ready=0.
  - Every channel's div=DEF_DIV, high=DEF_HIGH, phase=0.
  - FSM enters ALIGN.
- Reset applies mid-operation and has priority over cfg_write in the same cycle.
- FSM states:
  - ALIGN (1 cycle): all channel counters cleared; hold counters loaded from phase; outclk=0, outclk_en=0, locked=0, cfg_ready=0. Always goes to SETTLE next.
  - SETTLE: channels run. A settle counter starts in the first cycle in which every hold counter is 0 and counts LOCK_DELAY cycles, then the FSM goes to LOCKED.
  - LOCKED: locked=1.
- cfg_ready=1 in SETTLE and LOCKED only.
- Config writes:
  - A write with cfg_write=1 and cfg_ready=1 updates channel cfg_ch's div, high and phase at that edge, and the FSM enters ALIGN next cycle. All channels realign, not just the written one.
  - cfg_write while cfg_ready=0 is ignored.
  - cfg_ch >= NUM_CH: the write is accepted, no register changes, and the FSM still realigns.
- Channel i, per cycle in SETTLE/LOCKED:
  - If hold_i>0: hold_i decrements, cnt_i stays 0, outclk[i]=0, outclk_en[i]=0.
  - Else: outclk[i]=(cnt_i<high_i) and outclk_en[i]=(cnt_i==0 && high_i!=0); cnt_i then increments, wrapping to 0 when cnt_i==div_eff-1.
- Arithmetic rules:
  - div_eff=max(div,1).
  - div_eff=1 gives cnt always 0; outclk is constant high with outclk_en every cycle if high>=1, constant low otherwise.
  - high=0 gives constant low with no pulses.
  - high>=div_eff gives constant high with a pulse every div_eff cycles.
  - Comparisons are unsigned, CNT_W bits.
- Latency:
  - Accepted write at edge t: ALIGN in cycle t+1, first SETTLE cycle at t+2.
  - With phase 0, the channel's first outclk high and pulse appear at t+2.
  - locked=1 from t+2+max(phase)+LOCK_DELAY.
- Pulse/clock relation: outclk_en[i] coincides with the first high cycle of outclk[i].
- All outputs are registered, with no combinational path from cfg inputs to outputs.

Test Plan:
- Reset defaults: release rst at cycle 0 (ALIGN) → SETTLE from cycle 1; outclk[i] pattern 1,0,1,0…; outclk_en at cycles 1,3,5…; locked=1 from cycle 9 (LOCK_DELAY=8); cfg_ready=1 from cycle 1.
- Divide/duty: write ch1 div=5, high=2, phase=0 at edge t → outclk[1]=1,1,0,0,0 repeating from t+2; outclk_en[1] at t+2, t+7, t+12; all channels realign.
- Phase: ch0 phase=0, ch2 phase=3, both div=4, high=2 → outclk[2] is outclk[0] delayed 3 cycles; locked asserts 3+8 cycles after the first SETTLE cycle.
- Corners: div=0 and div=1 with high=1 → constant high with outclk_en every cycle; high=0 → constant 0 with no pulses; high=9, div=4 → constant high with a pulse every 4 cycles.
- Handshake: cfg_write held high 2 cycles → first write accepted; second lands in ALIGN (cfg_ready=0) and is ignored; no second realignment. cfg_ch=NUM_CH → realign, no config change.
- Reset mid-operation: assert rst in LOCKED together with cfg_write → next cycle all outputs 0 and defaults restored; the write is discarded.
